// File: rtl/core_axil_master.sv
// core_axil_master: turns a single-outstanding core load/store request into
// one AXI4-Lite read or write and returns a one-cycle response pulse.
// A saturating counter tracks non-OKAY responses for debug.
module core_axil_master #(
  parameter int ADDR_WIDTH    = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int ERR_CNT_WIDTH = 8
) (
  input  logic                      aclk,
  input  logic                      arst_n,
  // core request
  input  logic                      core_req_valid,
  output logic                      core_req_ready,
  input  logic                      core_req_write,
  input  logic                      core_req_priv,
  input  logic [ADDR_WIDTH-1:0]     core_req_addr,
  input  logic [DATA_WIDTH-1:0]     core_req_wdata,
  input  logic [DATA_WIDTH/8-1:0]   core_req_wstrb,
  // core response
  output logic                      core_rsp_valid,
  output logic [DATA_WIDTH-1:0]     core_rsp_rdata,
  output logic                      core_rsp_error,
  output logic [ERR_CNT_WIDTH-1:0]  err_count,
  // AXI4-Lite write address
  output logic [ADDR_WIDTH-1:0]     M_AXI_awaddr,
  output logic [2:0]                M_AXI_awprot,
  output logic                      M_AXI_awvalid,
  input  logic                      M_AXI_awready,
  // AXI4-Lite write data
  output logic [DATA_WIDTH-1:0]     M_AXI_wdata,
  output logic [DATA_WIDTH/8-1:0]   M_AXI_wstrb,
  output logic                      M_AXI_wvalid,
  input  logic                      M_AXI_wready,
  // AXI4-Lite write response
  input  logic [1:0]                M_AXI_bresp,
  input  logic                      M_AXI_bvalid,
  output logic                      M_AXI_bready,
  // AXI4-Lite read address
  output logic [ADDR_WIDTH-1:0]     M_AXI_araddr,
  output logic [2:0]                M_AXI_arprot,
  output logic                      M_AXI_arvalid,
  input  logic                      M_AXI_arready,
  // AXI4-Lite read data
  input  logic [DATA_WIDTH-1:0]     M_AXI_rdata,
  input  logic [1:0]                M_AXI_rresp,
  input  logic                      M_AXI_rvalid,
  output logic                      M_AXI_rready
);

  localparam logic [1:0] RESP_OKAY = 2'b00;

  typedef enum logic [2:0] {
    IDLE,
    WR_REQ,
    WR_RESP,
    RD_ADDR,
    RD_DATA,
    RESP
  } state_t;

  state_t state_reg, state_next;
  logic   aw_pend_reg, aw_pend_next;
  logic   w_pend_reg, w_pend_next;

  logic [ADDR_WIDTH-1:0]    addr_reg;
  logic [DATA_WIDTH-1:0]    wdata_reg;
  logic [DATA_WIDTH/8-1:0]  wstrb_reg;
  logic                     write_reg;
  logic                     priv_reg;
  logic [DATA_WIDTH-1:0]    rdata_reg;
  logic [1:0]               resp_reg;
  logic [ERR_CNT_WIDTH-1:0] err_count_reg;
  // Low throughout reset and for the first edge after it, so the core never
  // sees ready while the bridge is being held in reset.
  logic                     out_of_reset_reg;

  logic req_fire, aw_fire, w_fire;

  assign req_fire = core_req_valid && core_req_ready;
  assign aw_fire  = M_AXI_awvalid && M_AXI_awready;
  assign w_fire   = M_AXI_wvalid && M_AXI_wready;

  // Handshake and channel controls are pure decodes of registered state.
  assign core_req_ready = (state_reg == IDLE) && out_of_reset_reg;
  assign M_AXI_awvalid  = (state_reg == WR_REQ) && aw_pend_reg;
  assign M_AXI_wvalid   = (state_reg == WR_REQ) && w_pend_reg;
  assign M_AXI_bready   = (state_reg == WR_RESP);
  assign M_AXI_arvalid  = (state_reg == RD_ADDR);
  assign M_AXI_rready   = (state_reg == RD_DATA);

  // Address/data/strobe come straight from the request latches so they are
  // stable for the whole time the matching valid is held.
  assign M_AXI_awaddr = addr_reg;
  assign M_AXI_araddr = addr_reg;
  assign M_AXI_wdata  = wdata_reg;
  assign M_AXI_wstrb  = wstrb_reg;
  assign M_AXI_awprot = {2'b00, priv_reg};
  assign M_AXI_arprot = {2'b00, priv_reg};

  // Any non-OKAY response (EXOKAY included) is an error; data is only
  // forwarded for a successful load.
  assign core_rsp_valid = (state_reg == RESP);
  assign core_rsp_error = (resp_reg != RESP_OKAY);
  assign core_rsp_rdata = (!write_reg && (resp_reg == RESP_OKAY)) ? rdata_reg : '0;
  assign err_count      = err_count_reg;

  // State and outstanding-channel flags.
  always_ff @(posedge aclk) begin
    if (!arst_n) begin
      state_reg   <= IDLE;
      aw_pend_reg <= 1'b0;
      w_pend_reg  <= 1'b0;
    end else begin
      state_reg   <= state_next;
      aw_pend_reg <= aw_pend_next;
      w_pend_reg  <= w_pend_next;
    end
  end

  // Next-state logic; AW and W retire independently in WR_REQ.
  always_comb begin
    state_next   = state_reg;
    aw_pend_next = aw_pend_reg;
    w_pend_next  = w_pend_reg;
    case (state_reg)
      IDLE: begin
        if (req_fire) begin
          if (core_req_write) begin
            state_next   = WR_REQ;
            aw_pend_next = 1'b1;
            w_pend_next  = 1'b1;
          end else begin
            state_next = RD_ADDR;
          end
        end
      end
      WR_REQ: begin
        if (aw_fire) aw_pend_next = 1'b0;
        if (w_fire)  w_pend_next  = 1'b0;
        if (!aw_pend_next && !w_pend_next) state_next = WR_RESP;
      end
      WR_RESP: if (M_AXI_bvalid) state_next = RESP;
      RD_ADDR: if (M_AXI_arready) state_next = RD_DATA;
      RD_DATA: if (M_AXI_rvalid) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Request latches, response capture on the B/R handshake, error counter.
  always_ff @(posedge aclk) begin
    if (!arst_n) begin
      addr_reg         <= '0;
      wdata_reg        <= '0;
      wstrb_reg        <= '0;
      write_reg        <= 1'b0;
      priv_reg         <= 1'b0;
      rdata_reg        <= '0;
      resp_reg         <= RESP_OKAY;
      err_count_reg    <= '0;
      out_of_reset_reg <= 1'b0;
    end else begin
      out_of_reset_reg <= 1'b1;
      if (req_fire) begin
        addr_reg  <= core_req_addr;
        wdata_reg <= core_req_wdata;
        wstrb_reg <= core_req_wstrb;
        write_reg <= core_req_write;
        priv_reg  <= core_req_priv;
      end
      if (M_AXI_bvalid && M_AXI_bready) begin
        resp_reg <= M_AXI_bresp;
      end
      if (M_AXI_rvalid && M_AXI_rready) begin
        rdata_reg <= M_AXI_rdata;
        resp_reg  <= M_AXI_rresp;
      end
      if (core_rsp_valid && core_rsp_error && (err_count_reg != '1)) begin
        err_count_reg <= err_count_reg + ERR_CNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_core_axil_master.sv
// Testbench for core_axil_master: configurable-latency AXI4-Lite slave,
// channel monitor, table-driven vectors, randomized transactions against a
// behavioural model, and hand-written multi-cycle sequences.
module tb_core_axil_master;

  logic        aclk = 1'b0;
  logic        arst_n;
  logic        core_req_valid, core_req_ready, core_req_write, core_req_priv;
  logic [31:0] core_req_addr, core_req_wdata;
  logic [3:0]  core_req_wstrb;
  logic        core_rsp_valid, core_rsp_error;
  logic [31:0] core_rsp_rdata;
  logic [7:0]  err_count;
  logic [31:0] M_AXI_awaddr, M_AXI_wdata, M_AXI_araddr, M_AXI_rdata;
  logic [2:0]  M_AXI_awprot, M_AXI_arprot;
  logic        M_AXI_awvalid, M_AXI_awready, M_AXI_wvalid, M_AXI_wready;
  logic [3:0]  M_AXI_wstrb;
  logic [1:0]  M_AXI_bresp, M_AXI_rresp;
  logic        M_AXI_bvalid, M_AXI_bready, M_AXI_arvalid, M_AXI_arready;
  logic        M_AXI_rvalid, M_AXI_rready;

  always #5 aclk = ~aclk;

  core_axil_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .ERR_CNT_WIDTH(8)) dut (
    .aclk(aclk), .arst_n(arst_n),
    .core_req_valid(core_req_valid), .core_req_ready(core_req_ready),
    .core_req_write(core_req_write), .core_req_priv(core_req_priv),
    .core_req_addr(core_req_addr), .core_req_wdata(core_req_wdata),
    .core_req_wstrb(core_req_wstrb),
    .core_rsp_valid(core_rsp_valid), .core_rsp_rdata(core_rsp_rdata),
    .core_rsp_error(core_rsp_error), .err_count(err_count),
    .M_AXI_awaddr(M_AXI_awaddr), .M_AXI_awprot(M_AXI_awprot),
    .M_AXI_awvalid(M_AXI_awvalid), .M_AXI_awready(M_AXI_awready),
    .M_AXI_wdata(M_AXI_wdata), .M_AXI_wstrb(M_AXI_wstrb),
    .M_AXI_wvalid(M_AXI_wvalid), .M_AXI_wready(M_AXI_wready),
    .M_AXI_bresp(M_AXI_bresp), .M_AXI_bvalid(M_AXI_bvalid),
    .M_AXI_bready(M_AXI_bready),
    .M_AXI_araddr(M_AXI_araddr), .M_AXI_arprot(M_AXI_arprot),
    .M_AXI_arvalid(M_AXI_arvalid), .M_AXI_arready(M_AXI_arready),
    .M_AXI_rdata(M_AXI_rdata), .M_AXI_rresp(M_AXI_rresp),
    .M_AXI_rvalid(M_AXI_rvalid), .M_AXI_rready(M_AXI_rready)
  );

  // ---------------- slave model ----------------
  int          cfg_aw_d, cfg_w_d, cfg_b_d, cfg_ar_d, cfg_r_d;
  logic [1:0]  cfg_bresp, cfg_rresp;
  logic [31:0] cfg_rdata;
  int          aw_wait, w_wait, ar_wait, b_wait, r_wait;
  logic        aw_done, w_done, ar_done, bvalid_r, rvalid_r;
  logic        aw_hs, w_hs, ar_hs;

  assign M_AXI_awready = M_AXI_awvalid && (aw_wait >= cfg_aw_d);
  assign M_AXI_wready  = M_AXI_wvalid && (w_wait >= cfg_w_d);
  assign M_AXI_arready = M_AXI_arvalid && (ar_wait >= cfg_ar_d);
  assign aw_hs = M_AXI_awvalid && M_AXI_awready;
  assign w_hs  = M_AXI_wvalid && M_AXI_wready;
  assign ar_hs = M_AXI_arvalid && M_AXI_arready;
  assign M_AXI_bvalid = bvalid_r;
  assign M_AXI_rvalid = rvalid_r;
  // Junk on resp/data outside the valid cycle: only the handshake may be sampled.
  assign M_AXI_bresp = bvalid_r ? cfg_bresp : 2'b11;
  assign M_AXI_rresp = rvalid_r ? cfg_rresp : 2'b11;
  assign M_AXI_rdata = rvalid_r ? cfg_rdata : 32'hBAD0_BAD0;

  // Slave: delay counters for readies and for B/R response launch.
  always @(posedge aclk) begin
    if (!arst_n) begin
      aw_wait <= 0; w_wait <= 0; ar_wait <= 0; b_wait <= 0; r_wait <= 0;
      aw_done <= 1'b0; w_done <= 1'b0; ar_done <= 1'b0;
      bvalid_r <= 1'b0; rvalid_r <= 1'b0;
    end else begin
      aw_wait <= (M_AXI_awvalid && !M_AXI_awready) ? aw_wait + 1 : 0;
      w_wait  <= (M_AXI_wvalid && !M_AXI_wready) ? w_wait + 1 : 0;
      ar_wait <= (M_AXI_arvalid && !M_AXI_arready) ? ar_wait + 1 : 0;
      if (M_AXI_bvalid && M_AXI_bready) bvalid_r <= 1'b0;
      if (aw_hs) aw_done <= 1'b1;
      if (w_hs)  w_done  <= 1'b1;
      if (!bvalid_r && (aw_done || aw_hs) && (w_done || w_hs)) begin
        if (b_wait >= cfg_b_d) begin
          bvalid_r <= 1'b1; aw_done <= 1'b0; w_done <= 1'b0; b_wait <= 0;
        end else begin
          b_wait <= b_wait + 1;
        end
      end
      if (M_AXI_rvalid && M_AXI_rready) rvalid_r <= 1'b0;
      if (ar_hs) ar_done <= 1'b1;
      if (!rvalid_r && (ar_done || ar_hs)) begin
        if (r_wait >= cfg_r_d) begin
          rvalid_r <= 1'b1; ar_done <= 1'b0; r_wait <= 0;
        end else begin
          r_wait <= r_wait + 1;
        end
      end
    end
  end

  // ---------------- channel monitor ----------------
  typedef struct {
    logic [31:0] a;
    logic [3:0]  s;
    logic [2:0]  p;
    int          cyc;
  } ch_t;
  ch_t aw_q[$], w_q[$], ar_q[$];
  int  aw_cyc, w_cyc, ar_cyc, rsp_pulses, stab_viol;
  logic        p_awv, p_awr, p_wv, p_wr, p_arv, p_arr;
  logic [31:0] p_awaddr, p_wdata, p_araddr;
  logic [3:0]  p_wstrb;
  logic [2:0]  p_awprot, p_arprot;

  // Monitor: logs each AXI handshake with its valid duration, counts response
  // pulses, and flags any valid dropped or payload changed before ready.
  always @(negedge aclk) begin
    if (!arst_n) begin
      aw_cyc <= 0; w_cyc <= 0; ar_cyc <= 0;
      p_awv <= 1'b0; p_wv <= 1'b0; p_arv <= 1'b0;
    end else begin
      if (M_AXI_awvalid) begin
        if (M_AXI_awready) begin
          aw_q.push_back('{M_AXI_awaddr, 4'h0, M_AXI_awprot, aw_cyc + 1});
          aw_cyc <= 0;
        end else aw_cyc <= aw_cyc + 1;
      end
      if (M_AXI_wvalid) begin
        if (M_AXI_wready) begin
          w_q.push_back('{M_AXI_wdata, M_AXI_wstrb, 3'b000, w_cyc + 1});
          w_cyc <= 0;
        end else w_cyc <= w_cyc + 1;
      end
      if (M_AXI_arvalid) begin
        if (M_AXI_arready) begin
          ar_q.push_back('{M_AXI_araddr, 4'h0, M_AXI_arprot, ar_cyc + 1});
          ar_cyc <= 0;
        end else ar_cyc <= ar_cyc + 1;
      end
      if (core_rsp_valid) rsp_pulses <= rsp_pulses + 1;
      if ((p_awv && !p_awr && (!M_AXI_awvalid || M_AXI_awaddr != p_awaddr || M_AXI_awprot != p_awprot)) ||
          (p_wv && !p_wr && (!M_AXI_wvalid || M_AXI_wdata != p_wdata || M_AXI_wstrb != p_wstrb)) ||
          (p_arv && !p_arr && (!M_AXI_arvalid || M_AXI_araddr != p_araddr || M_AXI_arprot != p_arprot)))
        stab_viol <= stab_viol + 1;
      p_awv <= M_AXI_awvalid; p_awr <= M_AXI_awready;
      p_awaddr <= M_AXI_awaddr; p_awprot <= M_AXI_awprot;
      p_wv <= M_AXI_wvalid; p_wr <= M_AXI_wready;
      p_wdata <= M_AXI_wdata; p_wstrb <= M_AXI_wstrb;
      p_arv <= M_AXI_arvalid; p_arr <= M_AXI_arready;
      p_araddr <= M_AXI_araddr; p_arprot <= M_AXI_arprot;
    end
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_pass   = 0;
  int model_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    else n_pass++;
  endtask

  typedef struct {
    logic        wr;
    logic        pr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    int          aw_d, w_d, b_d, ar_d, r_d;
    logic [1:0]  resp;
    logic [31:0] sdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    logic [2:0]  exp_prot;
  } vec_t;

  function automatic vec_t mk(input logic wr, pr, input logic [31:0] addr, wdata,
                              input logic [3:0] strb, input int aw_d, w_d, b_d, ar_d, r_d,
                              input logic [1:0] resp, input logic [31:0] sdata, exp_rdata,
                              input logic exp_err, input logic [2:0] exp_prot);
    vec_t v;
    v.wr = wr; v.pr = pr; v.addr = addr; v.wdata = wdata; v.strb = strb;
    v.aw_d = aw_d; v.w_d = w_d; v.b_d = b_d; v.ar_d = ar_d; v.r_d = r_d;
    v.resp = resp; v.sdata = sdata; v.exp_rdata = exp_rdata;
    v.exp_err = exp_err; v.exp_prot = exp_prot;
    return v;
  endfunction

  // Reference model: expected response from the request and slave behaviour.
  function automatic vec_t model(input vec_t v);
    vec_t r = v;
    r.exp_err   = (v.resp != 2'b00);
    r.exp_rdata = (!v.wr && v.resp == 2'b00) ? v.sdata : 32'h0;
    r.exp_prot  = {2'b00, v.pr};
    return r;
  endfunction

  task automatic clear_logs();
    aw_q.delete(); w_q.delete(); ar_q.delete();
  endtask

  // One full request/response; called and returns at a negedge.
  task automatic run_txn(input string tag, input vec_t v);
    int   n, lat, exp_lat, mx;
    ch_t  r;
    cfg_aw_d = v.aw_d; cfg_w_d = v.w_d; cfg_b_d = v.b_d;
    cfg_ar_d = v.ar_d; cfg_r_d = v.r_d;
    cfg_bresp = v.resp; cfg_rresp = v.resp; cfg_rdata = v.sdata;
    core_req_write = v.wr; core_req_priv = v.pr; core_req_addr = v.addr;
    core_req_wdata = v.wdata; core_req_wstrb = v.strb; core_req_valid = 1'b1;
    n = 0;
    while (!core_req_ready && n < 50) begin @(negedge aclk); n++; end
    check({tag, " accept"}, core_req_ready, 1'b1);
    @(negedge aclk);
    // Scramble inputs: the bridge must use its latched copy.
    core_req_valid = 1'b0; core_req_addr = $urandom(); core_req_wdata = $urandom();
    core_req_wstrb = 4'($urandom_range(0, 15)); core_req_priv = ~v.pr; core_req_write = ~v.wr;
    lat = 1;
    while (!core_rsp_valid && lat < 100) begin @(negedge aclk); lat++; end
    mx = (v.aw_d > v.w_d) ? v.aw_d : v.w_d;
    exp_lat = v.wr ? (3 + mx + v.b_d) : (3 + v.ar_d + v.r_d);
    check({tag, " rsp_latency"}, lat, exp_lat);
    check({tag, " rsp_rdata"}, core_rsp_rdata, v.exp_rdata);
    check({tag, " rsp_error"}, core_rsp_error, v.exp_err);
    if (v.exp_err && model_err < 255) model_err++;
    @(negedge aclk);
    check({tag, " rsp_single_pulse"}, core_rsp_valid, 1'b0);
    check({tag, " ready_after"}, core_req_ready, 1'b1);
    check({tag, " err_count"}, err_count, model_err);
    check({tag, " aw_count"}, aw_q.size(), v.wr ? 1 : 0);
    check({tag, " w_count"}, w_q.size(), v.wr ? 1 : 0);
    check({tag, " ar_count"}, ar_q.size(), v.wr ? 0 : 1);
    if (v.wr && aw_q.size() > 0 && w_q.size() > 0) begin
      r = aw_q.pop_front();
      check({tag, " awaddr"}, r.a, v.addr);
      check({tag, " awprot"}, r.p, v.exp_prot);
      check({tag, " aw_cycles"}, r.cyc, v.aw_d + 1);
      r = w_q.pop_front();
      check({tag, " wdata"}, r.a, v.wdata);
      check({tag, " wstrb"}, r.s, v.strb);
      check({tag, " w_cycles"}, r.cyc, v.w_d + 1);
    end else if (!v.wr && ar_q.size() > 0) begin
      r = ar_q.pop_front();
      check({tag, " araddr"}, r.a, v.addr);
      check({tag, " arprot"}, r.p, v.exp_prot);
      check({tag, " ar_cycles"}, r.cyc, v.ar_d + 1);
    end
    clear_logs();
  endtask

  vec_t tbl[8];
  vec_t v;
  int   n, bad, pulses0;

  initial begin
    rsp_pulses = 0; stab_viol = 0;
    cfg_aw_d = 0; cfg_w_d = 0; cfg_b_d = 0; cfg_ar_d = 0; cfg_r_d = 0;
    cfg_bresp = 2'b00; cfg_rresp = 2'b00; cfg_rdata = 32'h0;
    arst_n = 1'b0; core_req_valid = 1'b0; core_req_write = 1'b0; core_req_priv = 1'b0;
    core_req_addr = 32'h0; core_req_wdata = 32'h0; core_req_wstrb = 4'h0;

    // Reset state
    repeat (3) @(negedge aclk);
    check("reset core_req_ready", core_req_ready, 1'b0);
    check("reset core_rsp_valid", core_rsp_valid, 1'b0);
    check("reset axi valids", {M_AXI_awvalid, M_AXI_wvalid, M_AXI_arvalid, M_AXI_bready, M_AXI_rready}, 5'b0);
    check("reset err_count", err_count, 8'd0);
    arst_n = 1'b1;
    @(negedge aclk);
    check("post-reset ready", core_req_ready, 1'b1);

    // Directed vectors (expected values worked out by hand)
    tbl[0] = mk(0, 0, 32'h10, 32'h0, 4'h0, 0, 0, 0, 0, 0, 2'b00, 32'hDEADBEEF, 32'hDEADBEEF, 0, 3'b000);
    tbl[1] = mk(1, 0, 32'h104, 32'hA5, 4'b0001, 3, 0, 0, 0, 0, 2'b00, 32'h0, 32'h0, 0, 3'b000);
    tbl[2] = mk(0, 0, 32'h20, 32'h0, 4'h0, 0, 0, 0, 0, 0, 2'b11, 32'h1234, 32'h0, 1, 3'b000);
    tbl[3] = mk(1, 1, 32'h200, 32'h12345678, 4'hF, 1, 1, 1, 0, 0, 2'b10, 32'h0, 32'h0, 1, 3'b001);
    tbl[4] = mk(0, 1, 32'h44, 32'h0, 4'h0, 0, 0, 0, 1, 0, 2'b01, 32'h5555, 32'h0, 1, 3'b001);
    tbl[5] = mk(0, 0, 32'h48, 32'h0, 4'h0, 0, 0, 0, 2, 3, 2'b00, 32'hCAFEF00D, 32'hCAFEF00D, 0, 3'b000);
    tbl[6] = mk(1, 0, 32'hFFFFFFFC, 32'hFFFFFFFF, 4'b1100, 0, 2, 2, 0, 0, 2'b00, 32'h0, 32'h0, 0, 3'b000);
    tbl[7] = mk(1, 1, 32'h8, 32'h0, 4'h0, 2, 1, 0, 0, 0, 2'b00, 32'h77, 32'h0, 0, 3'b001);
    for (int i = 0; i < 8; i++) run_txn($sformatf("vec%0d", i), tbl[i]);

    // Randomized transactions against the reference model
    for (int i = 0; i < 40; i++) begin
      v = mk($urandom_range(0, 1), $urandom_range(0, 1), $urandom(), $urandom(),
             4'($urandom_range(0, 15)), $urandom_range(0, 3), $urandom_range(0, 3),
             $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
             $urandom_range(0, 1) ? 2'b00 : 2'($urandom_range(1, 3)), $urandom(),
             32'h0, 1'b0, 3'b000);
      run_txn($sformatf("rnd%0d", i), model(v));
    end

    // Backpressure: second request held high while the write waits for B
    cfg_aw_d = 0; cfg_w_d = 0; cfg_b_d = 5; cfg_ar_d = 0; cfg_r_d = 0;
    cfg_bresp = 2'b00; cfg_rresp = 2'b00; cfg_rdata = 32'h600DCAFE;
    core_req_write = 1'b1; core_req_priv = 1'b0; core_req_addr = 32'h300;
    core_req_wdata = 32'h11; core_req_wstrb = 4'hF; core_req_valid = 1'b1;
    n = 0;
    while (!core_req_ready && n < 50) begin @(negedge aclk); n++; end
    @(negedge aclk);
    core_req_write = 1'b0; core_req_addr = 32'h304;
    bad = 0; n = 1;
    while (!core_rsp_valid && n < 100) begin
      if (core_req_ready) bad++;
      @(negedge aclk); n++;
    end
    if (core_req_ready) bad++;
    check("bp write rsp_latency", n, 8);
    check("bp ready_low_while_busy", bad, 0);
    check("bp no_ar_before_b", ar_q.size(), 0);
    @(negedge aclk);
    check("bp ready_in_idle", core_req_ready, 1'b1);
    @(negedge aclk);
    core_req_valid = 1'b0;
    n = 0;
    while (!core_rsp_valid && n < 100) begin @(negedge aclk); n++; end
    check("bp read rdata", core_rsp_rdata, 32'h600DCAFE);
    check("bp read error", core_rsp_error, 1'b0);
    @(negedge aclk);
    check("bp aw_count", aw_q.size(), 1);
    check("bp ar_count", ar_q.size(), 1);
    if (aw_q.size() > 0) check("bp awaddr", aw_q[0].a, 32'h300);
    if (ar_q.size() > 0) check("bp araddr", ar_q[0].a, 32'h304);
    clear_logs();

    // Reset while waiting for read data
    cfg_ar_d = 0; cfg_r_d = 20;
    core_req_write = 1'b0; core_req_addr = 32'h400; core_req_valid = 1'b1;
    n = 0;
    while (!core_req_ready && n < 50) begin @(negedge aclk); n++; end
    @(negedge aclk);
    core_req_valid = 1'b0;
    n = 0;
    while (!M_AXI_rready && n < 50) begin @(negedge aclk); n++; end
    check("midrst in RD_DATA", M_AXI_rready, 1'b1);
    pulses0 = rsp_pulses;
    arst_n = 1'b0;
    @(negedge aclk);
    check("midrst arvalid", M_AXI_arvalid, 1'b0);
    check("midrst rready", M_AXI_rready, 1'b0);
    check("midrst core_req_ready", core_req_ready, 1'b0);
    check("midrst err_count", err_count, 8'd0);
    @(negedge aclk);
    check("midrst core_req_ready held", core_req_ready, 1'b0);
    arst_n = 1'b1;
    @(negedge aclk);
    check("midrst ready after release", core_req_ready, 1'b1);
    repeat (3) @(negedge aclk);
    check("midrst no rsp pulse", rsp_pulses, pulses0);
    model_err = 0;
    clear_logs();

    // Error counter saturation: 300 DECERR reads
    for (int i = 0; i < 300; i++)
      run_txn($sformatf("sat%0d", i),
              mk(0, 0, 32'h20, 32'h0, 4'h0, 0, 0, 0, 0, 0, 2'b11, 32'h1234, 32'h0, 1, 3'b000));
    check("saturated err_count", err_count, 8'd255);

    check("channel stability violations", stab_viol, 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
